// File: rtl/dm_responder.sv
// Single-outstanding load/store memory responder with programmable wait states.
// Requests are latched on accept; the response is held until the initiator takes it.
module dm_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_write_data,
    input  logic [3:0]            req_byte_enable,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_read_data,
    output logic                  resp_error
);

    localparam int DEPTH       = 1 << ADDR_WIDTH;
    localparam int HI_SHIFT    = ADDR_WIDTH + 2;
    localparam int WAIT_INIT_I = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
    localparam logic [3:0] WAIT_INIT = WAIT_INIT_I[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic                    ready_r;
    logic                    resp_valid_r;
    logic                    resp_error_r;
    logic [31:0]             resp_data_r;
    logic                    lat_write_r;
    logic [31:0]             lat_addr_r;
    logic [31:0]             lat_data_r;
    logic [3:0]              lat_be_r;
    logic [31:0]             mem_r [0:DEPTH-1];

    logic                    accept_s;
    logic                    enter_resp_s;
    logic                    cur_write_s;
    logic [31:0]             cur_addr_s;
    logic [31:0]             cur_data_s;
    logic [3:0]              cur_be_s;
    logic                    err_s;
    logic [ADDR_WIDTH-1:0]   idx_s;
    logic [31:0]             rd_s;
    logic                    commit_s;

    // Misaligned or beyond the implemented word range.
    function automatic logic addr_error(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> HI_SHIFT) != 32'd0);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

    // Reset gating keeps ready low while reset_n is asserted.
    assign req_ready      = ready_r & reset_n;
    assign resp_valid     = resp_valid_r;
    assign resp_error     = resp_error_r;
    assign resp_read_data = resp_data_r;
    assign accept_s       = req_valid & req_ready;

    // Select the request being resolved: live inputs on a zero-wait accept, latched copy otherwise.
    always_comb begin
        cur_write_s  = lat_write_r;
        cur_addr_s   = lat_addr_r;
        cur_data_s   = lat_data_r;
        cur_be_s     = lat_be_r;
        enter_resp_s = 1'b0;
        if (state_r == ST_IDLE) begin
            cur_write_s  = req_write;
            cur_addr_s   = req_addr;
            cur_data_s   = req_write_data;
            cur_be_s     = req_byte_enable;
            enter_resp_s = accept_s && (WAIT_CYCLES == 0);
        end else if (state_r == ST_WAIT) begin
            enter_resp_s = (cnt_r == 4'd0);
        end else begin
            enter_resp_s = 1'b0;
        end
    end

    // Address decode, read mux and store-commit qualification.
    always_comb begin
        err_s    = addr_error(cur_addr_s);
        idx_s    = cur_addr_s[ADDR_WIDTH+1:2];
        commit_s = enter_resp_s & cur_write_s & ~err_s;
        if (!cur_write_s && !err_s) begin
            rd_s = mem_r[idx_s];
        end else begin
            rd_s = 32'd0;
        end
    end

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            resp_data_r  <= 32'd0;
            lat_write_r  <= 1'b0;
            lat_addr_r   <= 32'd0;
            lat_data_r   <= 32'd0;
            lat_be_r     <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        lat_write_r <= req_write;
                        lat_addr_r  <= req_addr;
                        lat_data_r  <= req_write_data;
                        lat_be_r    <= req_byte_enable;
                        ready_r     <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_error_r <= err_s;
                            resp_data_r  <= rd_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_error_r <= err_s;
                        resp_data_r  <= rd_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_r      <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                        ready_r      <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= 4'd0;
                    ready_r      <= 1'b1;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Memory array is deliberately not reset; stores commit on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], cur_data_s, cur_be_s);
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder (ADDR_WIDTH=10, WAIT_CYCLES=2).
module tb_dm_responder;

    localparam int WAITS = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_write_data = 32'd0;
    logic [3:0]  req_byte_enable = 4'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_read_data;
    logic        resp_error;

    int n_cmp = 0;
    int n_err = 0;

    dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WAITS)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_write_data  (req_write_data),
        .req_byte_enable (req_byte_enable),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_read_data  (resp_read_data),
        .resp_error      (resp_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // One full request/response; the req_* bus is scrambled while busy to show it is ignored.
    task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be,
                            input logic [31:0] exp_data, input logic exp_err, input int hold);
        int lat;
        @(negedge clk);
        req_valid       = 1'b1;
        req_write       = we;
        req_addr        = addr;
        req_write_data  = data;
        req_byte_enable = be;
        chk({tag, ":ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_write       = ~we;
        req_addr        = 32'h0000_0020;
        req_write_data  = $urandom;
        req_byte_enable = 4'hF;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;
        chk({tag, ":latency"}, 32'(lat), 32'(WAITS + 1));
        chk({tag, ":error"}, 32'(resp_error), 32'(exp_err));
        chk({tag, ":data"}, resp_read_data, exp_data);
        chk({tag, ":busy"}, 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, ":hold_data"}, resp_read_data, exp_data);
            chk({tag, ":hold_error"}, 32'(resp_error), 32'(exp_err));
            chk({tag, ":hold_busy"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, ":done_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, ":done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst:ready", 32'(req_ready), 32'd0);
        chk("rst:valid", 32'(resp_valid), 32'd0);
        chk("rst:error", 32'(resp_error), 32'd0);
        chk("rst:data", resp_read_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel:ready", 32'(req_ready), 32'd1);

        // Basic store/load and byte lanes
        transact("st10",    1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'd0,         1'b0, 0);
        transact("ld10",    1'b0, 32'h0000_0010, 32'd0,         4'b0000, 32'hDEAD_BEEF, 1'b0, 0);
        transact("st10b0",  1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, 32'd0,         1'b0, 0);
        transact("ld10b",   1'b0, 32'h0000_0010, 32'd0,         4'b0000, 32'hDEAD_BEAA, 1'b0, 0);
        transact("st10be0", 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'd0,         1'b0, 0);
        transact("ld10c",   1'b0, 32'h0000_0010, 32'd0,         4'b0000, 32'hDEAD_BEAA, 1'b0, 0);

        // Error cases leave memory untouched
        transact("ld12",    1'b0, 32'h0000_0012, 32'd0,         4'b0000, 32'd0,         1'b1, 0);
        transact("ld1000",  1'b0, 32'h0000_1000, 32'd0,         4'b0000, 32'd0,         1'b1, 0);
        transact("st1010",  1'b1, 32'h0000_1010, 32'h1111_1111, 4'b1111, 32'd0,         1'b1, 0);
        transact("st11",    1'b1, 32'h0000_0011, 32'h2222_2222, 4'b1111, 32'd0,         1'b1, 0);
        transact("ld10d",   1'b0, 32'h0000_0010, 32'd0,         4'b0000, 32'hDEAD_BEAA, 1'b0, 0);

        // Top word and backpressure
        transact("stffc",   1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 4'b1111, 32'd0,         1'b0, 0);
        transact("ldffc",   1'b0, 32'h0000_0FFC, 32'd0,         4'b0000, 32'h0BAD_CAFE, 1'b0, 5);

        // Reset in WAIT aborts the store
        transact("st20",    1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 32'd0,         1'b0, 0);
        @(negedge clk);
        req_valid       = 1'b1;
        req_write       = 1'b1;
        req_addr        = 32'h0000_0020;
        req_write_data  = 32'h1234_5678;
        req_byte_enable = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("abort:ready", 32'(req_ready), 32'd0);
        chk("abort:valid", 32'(resp_valid), 32'd0);
        chk("abort:error", 32'(resp_error), 32'd0);
        chk("abort:data", resp_read_data, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort:no_resp", 32'(resp_valid), 32'd0);
        end
        transact("ld20",    1'b0, 32'h0000_0020, 32'd0,         4'b0000, 32'hCAFE_F00D, 1'b0, 0);

        // Sparse lane mask
        transact("st20m",   1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1010, 32'd0,         1'b0, 0);
        transact("ld20m",   1'b0, 32'h0000_0020, 32'd0,         4'b0000, 32'h11FE_330D, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
